fake_n64_console_rx: RTL and testbench
======================================

// Module: fake_n64_console_rx
// PURPOSE
// - Joybus receiver for the fake N64 controller. Samples the shared data line and decodes console
//   bits from their pulse widths: 0 = L,L,L,H and 1 = L,H,H,H.
// - Assembles the bits into bytes and strips the console stop bit (L,H,H,Z).
// - Delivers a byte stream plus frame-done/error strobes to the command handler, which drives the TX stage.
// PARAMETERS
// - LEVEL_WIDTH  2                 clk cycles per Joybus level, same value as the TX stage.
// - IDLE_CYCLES  2*4*LEVEL_WIDTH   consecutive high cycles that end a frame; must be > 3*LEVEL_WIDTH.
// - Derived localparam BIT_WIDTH = 4*LEVEL_WIDTH.
// PORTS
// - clk             in   1  system clock
// - reset           in   1  synchronous, active-low reset
// - data_rx         in   1  Joybus line, pulled high when released
// - rx_byte         out  8  decoded byte, MSB received first
// - rx_byte_valid   out  1  1-cycle strobe, rx_byte is valid
// - frame_done      out  1  1-cycle strobe, frame ended with a good stop bit
// - frame_byte_cnt  out  6  byte count of the last frame; saturates at 63; valid with frame_done
// - frame_error     out  1  1-cycle strobe, malformed frame
// - busy            out  1  high from first falling edge until frame_done/frame_error
// BEHAVIOUR
// - Clock and reset: one clock, clk. reset is synchronous and active-low.
// - Reset values: all outputs 0, state DISARMED, all counters 0.
// - Mid-frame reset: the partial frame is discarded and no strobe is emitted.
// - Signal used for decoding is line_s: data_rx after optional sync; see CONFIGURATION.
// - States:
//   - DISARMED: line_s must stay high for IDLE_CYCLES consecutive cycles -> IDLE.
//     Guards against joining a frame mid-stream.
//   - IDLE: on line_s==0 -> LOW. Clear low_cnt to 1, bit_cnt to 0, byte count to 0. Raise busy.
//   - LOW: increment low_cnt, 8-bit saturating. If low_cnt > BIT_WIDTH -> ERR.
//     On line_s==1, decode the bit, shift it into sreg, increment bit_cnt, clear high_cnt -> HIGH.
//     Decode: low_cnt < 2*LEVEL_WIDTH gives 1; otherwise 0.
//   - HIGH: increment high_cnt.
//     On line_s==0 -> LOW. If bit_cnt==9, the 9th bit is data: keep sreg[0] as bit 1 of the next byte, bit_cnt=1.
//     If high_cnt reaches IDLE_CYCLES, end the frame:
//       - Good frame: bit_cnt==1, sreg[0]==1, at least 1 byte received. Pulse frame_done, drive frame_byte_cnt.
//       - Otherwise pulse frame_error.
//       - In both cases drop busy -> IDLE.
//   - ERR: pulse frame_error once -> DISARMED.
// - Byte emission:
//   - When bit_cnt reaches 8 the byte is held pending, because the 9th bit may be the stop bit.
//   - The pending byte goes out as rx_byte/rx_byte_valid in the cycle after the next falling edge,
//     or in the cycle after the 9th bit is decoded.
//   - Net effect: every byte is emitted exactly once, before frame_done. frame_done never shares a cycle with rx_byte_valid.
// - Latency: rx_byte_valid comes at most BIT_WIDTH+2 cycles after the last level of that byte (excluding sync delay).
// - Boundaries:
//   - A frame made only of a stop bit -> frame_error.
//   - Leftover bits other than exactly the stop bit -> frame_error. Bytes already emitted are not retracted.
//   - Byte count above 63 saturates; no error.
//   - A 1-cycle low glitch decodes as bit 1 (low_cnt=1); the stop-bit check catches it.
// CONFIGURATION
// - FAKE_N64_RX_SYNC_EN defined: data_rx passes a 2-flop synchronizer, reset value 1, so line_s lags by 2 cycles.
// - Undefined: line_s = data_rx. Input must be synchronous to clk, as in the TX-to-RX loopback bench.
// STRUCTURE
// - Shared include fake_n64_joybus_defs.vh holds:
//   - LEVEL_WIDTH and BIT_WIDTH defaults;
//   - command codes CMD_INFO=8'h00, CMD_STATUS=8'h01, CMD_RESET=8'hFF;
//   - FSM state encodings.
// - One sub-module: fake_n64_rx_sync, the 2-flop synchronizer, instantiated only under FAKE_N64_RX_SYNC_EN.
// - Level counting uses inline counters. n_bit_counter is not reused: it lacks saturation.
// TESTING
// Default parameters, sync disabled. Bit waveforms: 0 = 6 low/2 high; 1 = 2 low/6 high; stop = 2 low, then idle.
// - Frame 8'h01 + stop, then 16 cycles high -> one rx_byte_valid with 8'h01, then frame_done with frame_byte_cnt=1.
// - Frame 8'h00 + stop -> rx_byte=8'h00, frame_done; busy high for the whole frame and 0 after.
// - Frame 8'h03, 8'h80, 8'h01 + stop -> bytes 03,80,01 in order, then frame_done with frame_byte_cnt=3.
// - Line held low 20 cycles -> frame_error once. A following 8'h01 frame is rejected until 16 idle cycles have passed.
// - Frame 8'h01 + 5 bits, then idle -> rx_byte=8'h01, then frame_error; no frame_done.
// - reset low for 1 cycle mid-byte, then 16 idle cycles and frame 8'hFF -> no strobes from the cut frame; 8'hFF then frame_done.

Source files
------------

// File: rtl/fake_n64_console_rx_pkg.sv
// rtl/fake_n64_console_rx_pkg.sv - shared Joybus timing defaults, command codes and RX state encoding
package fake_n64_console_rx_pkg;

   // Level timing shared with the TX stage
   localparam int LEVEL_WIDTH_DEF = 2;
   localparam int BIT_WIDTH_DEF   = 4 * LEVEL_WIDTH_DEF;

   // Console command codes seen by the command handler
   localparam logic [7:0] CMD_INFO   = 8'h00;
   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_RESET  = 8'hFF;

   typedef enum logic [2:0] {
      ST_DISARMED = 3'd0,
      ST_IDLE     = 3'd1,
      ST_LOW      = 3'd2,
      ST_HIGH     = 3'd3,
      ST_ERR      = 3'd4
   } rx_state_t;

   // Level counters stick at all-ones instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/fake_n64_console_rx_if.sv
// rtl/fake_n64_console_rx_if.sv - Joybus line input and decoded byte/frame outputs of the console receiver
interface fake_n64_console_rx_if;

   logic       data_rx;
   logic [7:0] rx_byte;
   logic       rx_byte_valid;
   logic       frame_done;
   logic [5:0] frame_byte_cnt;
   logic       frame_error;
   logic       busy;

   // Receiver side: samples the line, produces bytes and frame strobes
   modport master (
      input  data_rx,
      output rx_byte,
      output rx_byte_valid,
      output frame_done,
      output frame_byte_cnt,
      output frame_error,
      output busy
   );

   // Line driver / command handler side
   modport slave (
      output data_rx,
      input  rx_byte,
      input  rx_byte_valid,
      input  frame_done,
      input  frame_byte_cnt,
      input  frame_error,
      input  busy
   );

endinterface

// File: rtl/fake_n64_console_rx_sync.sv
// rtl/fake_n64_console_rx_sync.sv - 2-flop synchronizer for the Joybus line, resets to released (high)
module fake_n64_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   // Two-stage resync; reset value 1 matches an idle, pulled-up line
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_meta <= 1'b1;
         r_q    <= 1'b1;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/fake_n64_console_rx.sv
// rtl/fake_n64_console_rx.sv - Joybus console-bit receiver; FAKE_N64_RX_SYNC_EN adds a 2-flop line synchronizer
module fake_n64_console_rx
   import fake_n64_console_rx_pkg::*;
#(
   parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF,
   parameter int IDLE_CYCLES = 2 * 4 * LEVEL_WIDTH
) (
   input  logic                        clk,
   input  logic                        reset,
   fake_n64_console_rx_if.master       bus
);

   localparam int BIT_WIDTH = 4 * LEVEL_WIDTH;

   localparam logic [7:0] c_bit_width = 8'(BIT_WIDTH);
   localparam logic [7:0] c_one_max   = 8'(2 * LEVEL_WIDTH);
   localparam logic [7:0] c_idle      = 8'(IDLE_CYCLES);

   logic w_line;

`ifdef FAKE_N64_RX_SYNC_EN
   fake_n64_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (bus.data_rx),
      .o_q   (w_line)
   );
`else
   assign w_line = bus.data_rx;
`endif

   rx_state_t  r_state,  w_state_nxt;
   logic [7:0] r_low_cnt,  w_low_cnt_nxt;
   logic [7:0] r_high_cnt, w_high_cnt_nxt;
   logic [3:0] r_bit_cnt,  w_bit_cnt_nxt;
   logic [7:0] r_sreg,     w_sreg_nxt;
   logic [5:0] r_byte_cnt, w_byte_cnt_nxt;

   logic [7:0] r_rx_byte,        w_rx_byte_nxt;
   logic       r_rx_byte_valid,  w_rx_byte_valid_nxt;
   logic       r_frame_done,     w_frame_done_nxt;
   logic [5:0] r_frame_byte_cnt, w_frame_byte_cnt_nxt;
   logic       r_frame_error,    w_frame_error_nxt;
   logic       r_busy,           w_busy_nxt;

   logic       w_bit;
   logic       w_good_frame;

   // Short low phase is a 1, long low phase is a 0
   assign w_bit = (r_low_cnt < c_one_max);

   // A good frame ends with exactly one leftover bit, which must be the stop bit (1)
   assign w_good_frame = (r_bit_cnt == 4'd1) && r_sreg[0] && (r_byte_cnt != 6'd0);

   // State and datapath register, all outputs registered
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state          <= ST_DISARMED;
         r_low_cnt        <= '0;
         r_high_cnt       <= '0;
         r_bit_cnt        <= '0;
         r_sreg           <= '0;
         r_byte_cnt       <= '0;
         r_rx_byte        <= '0;
         r_rx_byte_valid  <= 1'b0;
         r_frame_done     <= 1'b0;
         r_frame_byte_cnt <= '0;
         r_frame_error    <= 1'b0;
         r_busy           <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_low_cnt        <= w_low_cnt_nxt;
         r_high_cnt       <= w_high_cnt_nxt;
         r_bit_cnt        <= w_bit_cnt_nxt;
         r_sreg           <= w_sreg_nxt;
         r_byte_cnt       <= w_byte_cnt_nxt;
         r_rx_byte        <= w_rx_byte_nxt;
         r_rx_byte_valid  <= w_rx_byte_valid_nxt;
         r_frame_done     <= w_frame_done_nxt;
         r_frame_byte_cnt <= w_frame_byte_cnt_nxt;
         r_frame_error    <= w_frame_error_nxt;
         r_busy           <= w_busy_nxt;
      end
   end

   // Next-state, level counting, bit decode, byte emission and frame-end checks
   always_comb begin
      w_state_nxt          = r_state;
      w_low_cnt_nxt        = r_low_cnt;
      w_high_cnt_nxt       = r_high_cnt;
      w_bit_cnt_nxt        = r_bit_cnt;
      w_sreg_nxt           = r_sreg;
      w_byte_cnt_nxt       = r_byte_cnt;
      w_rx_byte_nxt        = r_rx_byte;
      w_rx_byte_valid_nxt  = 1'b0;
      w_frame_done_nxt     = 1'b0;
      w_frame_byte_cnt_nxt = r_frame_byte_cnt;
      w_frame_error_nxt    = 1'b0;
      w_busy_nxt           = r_busy;

      case (r_state)
         ST_DISARMED: begin
            // Only arm after a full idle gap so we never join a frame mid-stream
            if (w_line) begin
               w_high_cnt_nxt = sat_inc8(r_high_cnt);
               if (w_high_cnt_nxt >= c_idle) begin
                  w_state_nxt    = ST_IDLE;
                  w_high_cnt_nxt = '0;
               end
            end else begin
               w_high_cnt_nxt = '0;
            end
         end

         ST_IDLE: begin
            if (!w_line) begin
               w_state_nxt    = ST_LOW;
               w_low_cnt_nxt  = 8'd1;
               w_bit_cnt_nxt  = '0;
               w_byte_cnt_nxt = '0;
               w_busy_nxt     = 1'b1;
            end
         end

         ST_LOW: begin
            if (!w_line) begin
               w_low_cnt_nxt = sat_inc8(r_low_cnt);
               if (w_low_cnt_nxt > c_bit_width) begin
                  w_state_nxt = ST_ERR;
               end
            end else begin
               w_sreg_nxt     = {r_sreg[6:0], w_bit};
               w_high_cnt_nxt = '0;
               w_state_nxt    = ST_HIGH;
               if (r_bit_cnt == 4'd8) begin
                  // 9th bit proves the pending byte was data; it becomes bit 1 of the next byte
                  w_rx_byte_nxt       = r_sreg;
                  w_rx_byte_valid_nxt = 1'b1;
                  w_bit_cnt_nxt       = 4'd1;
                  if (r_byte_cnt != 6'd63) begin
                     w_byte_cnt_nxt = r_byte_cnt + 6'd1;
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               end
            end
         end

         ST_HIGH: begin
            if (!w_line) begin
               w_state_nxt   = ST_LOW;
               w_low_cnt_nxt = 8'd1;
            end else begin
               w_high_cnt_nxt = sat_inc8(r_high_cnt);
               if (w_high_cnt_nxt >= c_idle) begin
                  if (w_good_frame) begin
                     w_frame_done_nxt     = 1'b1;
                     w_frame_byte_cnt_nxt = r_byte_cnt;
                  end else begin
                     w_frame_error_nxt = 1'b1;
                  end
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         ST_ERR: begin
            w_frame_error_nxt = 1'b1;
            w_busy_nxt        = 1'b0;
            w_high_cnt_nxt    = '0;
            w_state_nxt       = ST_DISARMED;
         end

         default: begin
            w_state_nxt    = ST_DISARMED;
            w_high_cnt_nxt = '0;
         end
      endcase
   end

   assign bus.rx_byte        = r_rx_byte;
   assign bus.rx_byte_valid  = r_rx_byte_valid;
   assign bus.frame_done     = r_frame_done;
   assign bus.frame_byte_cnt = r_frame_byte_cnt;
   assign bus.frame_error    = r_frame_error;
   assign bus.busy           = r_busy;

endmodule

// File: tb/tb_fake_n64_console_rx.sv
// tb/tb_fake_n64_console_rx.sv - directed self-checking bench for fake_n64_console_rx
module tb_fake_n64_console_rx;

   logic clk;
   logic rst_n;

   fake_n64_console_rx_if intf ();

   fake_n64_console_rx dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   logic [7:0] got_bytes[$];
   int n_done;
   int n_err;
   int n_overlap;
   int n_busy_gap;
   int bytes_at_done;
   int last_cnt;
   bit frame_active;

   // Recorder of DUT strobes, sampled on the falling edge
   always @(negedge clk) begin
      if (intf.rx_byte_valid) got_bytes.push_back(intf.rx_byte);
      if (intf.frame_done) begin
         n_done++;
         last_cnt = int'(intf.frame_byte_cnt);
         bytes_at_done = got_bytes.size();
      end
      if (intf.frame_error) n_err++;
      if (intf.frame_done && intf.rx_byte_valid) n_overlap++;
      if (frame_active && !intf.busy) n_busy_gap++;
   end

   task automatic clear_mon();
      got_bytes.delete();
      n_done = 0;
      n_err = 0;
      n_overlap = 0;
      n_busy_gap = 0;
      bytes_at_done = -1;
      last_cnt = -1;
   endtask

   task automatic level(input logic v, input int n);
      repeat (n) begin
         intf.data_rx = v;
         @(negedge clk);
      end
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         level(1'b0, 2);
         level(1'b1, 6);
      end else begin
         level(1'b0, 6);
         level(1'b1, 2);
      end
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic send_stop_idle(input int n);
      level(1'b0, 2);
      level(1'b1, n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      intf.data_rx = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (intf.rx_byte_valid !== 1'b0 || intf.frame_done !== 1'b0 || intf.frame_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_strobes got valid=%b done=%b err=%b want 0,0,0", intf.rx_byte_valid, intf.frame_done, intf.frame_error);
      end
      checks++;
      if (intf.busy !== 1'b0 || intf.rx_byte !== 8'h00 || intf.frame_byte_cnt !== 6'd0) begin
         failures++;
         $display("FAIL reset_values got busy=%b byte=%h cnt=%0d want 0,00,0", intf.busy, intf.rx_byte, intf.frame_byte_cnt);
      end
      rst_n = 1'b1;
      level(1'b1, 20);
   endtask

   task automatic test_single_01();
      clear_mon();
      send_byte(8'h01);
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 1) begin
         failures++;
         $display("FAIL single_count got %0d bytes want 1", got_bytes.size());
      end else begin
         checks++;
         if (got_bytes[0] !== 8'h01) begin
            failures++;
            $display("FAIL single_byte got %h want 01", got_bytes[0]);
         end
      end
      checks++;
      if (n_done !== 1 || last_cnt !== 1 || n_err !== 0) begin
         failures++;
         $display("FAIL single_done got done=%0d cnt=%0d err=%0d want 1,1,0", n_done, last_cnt, n_err);
      end
      checks++;
      if (bytes_at_done !== 1 || n_overlap !== 0) begin
         failures++;
         $display("FAIL single_order got bytes_before_done=%0d overlap=%0d want 1,0", bytes_at_done, n_overlap);
      end
   endtask

   task automatic test_zero_busy();
      clear_mon();
      level(1'b0, 1);
      frame_active = 1'b1;
      level(1'b0, 5);
      level(1'b1, 2);
      for (int i = 0; i < 7; i++) send_bit(1'b0);
      level(1'b0, 2);
      level(1'b1, 16);
      frame_active = 1'b0;
      level(1'b1, 8);
      checks++;
      if (got_bytes.size() !== 1 || (got_bytes.size() == 1 && got_bytes[0] !== 8'h00)) begin
         failures++;
         $display("FAIL zero_byte got %0d bytes first=%h want 1 byte 00", got_bytes.size(), (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx);
      end
      checks++;
      if (n_done !== 1 || n_err !== 0) begin
         failures++;
         $display("FAIL zero_done got done=%0d err=%0d want 1,0", n_done, n_err);
      end
      checks++;
      if (n_busy_gap !== 0) begin
         failures++;
         $display("FAIL zero_busy_in_frame got %0d low cycles want 0", n_busy_gap);
      end
      checks++;
      if (intf.busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_busy_after got %b want 0", intf.busy);
      end
   endtask

   task automatic test_multi();
      logic [7:0] exp_b [3];
      exp_b[0] = 8'h03;
      exp_b[1] = 8'h80;
      exp_b[2] = 8'h01;
      clear_mon();
      for (int i = 0; i < 3; i++) send_byte(exp_b[i]);
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 3) begin
         failures++;
         $display("FAIL multi_count got %0d want 3", got_bytes.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_bytes[i] !== exp_b[i]) begin
               failures++;
               $display("FAIL multi_byte%0d got %h want %h", i, got_bytes[i], exp_b[i]);
            end
         end
      end
      checks++;
      if (n_done !== 1 || last_cnt !== 3 || bytes_at_done !== 3 || n_err !== 0) begin
         failures++;
         $display("FAIL multi_done got done=%0d cnt=%0d before=%0d err=%0d want 1,3,3,0", n_done, last_cnt, bytes_at_done, n_err);
      end
   endtask

   task automatic test_long_low();
      clear_mon();
      level(1'b0, 20);
      level(1'b1, 4);
      checks++;
      if (n_err !== 1 || intf.busy !== 1'b0) begin
         failures++;
         $display("FAIL long_low_error got err=%0d busy=%b want 1,0", n_err, intf.busy);
      end
      send_byte(8'h01);
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 0 || n_done !== 0 || n_err !== 1) begin
         failures++;
         $display("FAIL disarmed_reject got bytes=%0d done=%0d err=%0d want 0,0,1", got_bytes.size(), n_done, n_err);
      end
      clear_mon();
      send_byte(8'h01);
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 1 || n_done !== 1 || n_err !== 0 || (got_bytes.size() == 1 && got_bytes[0] !== 8'h01)) begin
         failures++;
         $display("FAIL rearmed_frame got bytes=%0d done=%0d err=%0d want 1,1,0", got_bytes.size(), n_done, n_err);
      end
   endtask

   task automatic test_partial();
      logic [4:0] extra;
      extra = 5'b10110;
      clear_mon();
      send_byte(8'h01);
      for (int i = 4; i >= 0; i--) send_bit(extra[i]);
      level(1'b1, 24);
      checks++;
      if (got_bytes.size() !== 1 || (got_bytes.size() == 1 && got_bytes[0] !== 8'h01)) begin
         failures++;
         $display("FAIL partial_byte got %0d bytes want 1 byte 01", got_bytes.size());
      end
      checks++;
      if (n_err !== 1 || n_done !== 0) begin
         failures++;
         $display("FAIL partial_error got err=%0d done=%0d want 1,0", n_err, n_done);
      end
   endtask

   task automatic test_stop_only();
      clear_mon();
      send_stop_idle(24);
      checks++;
      if (n_err !== 1 || n_done !== 0 || got_bytes.size() !== 0) begin
         failures++;
         $display("FAIL stop_only got err=%0d done=%0d bytes=%0d want 1,0,0", n_err, n_done, got_bytes.size());
      end
   endtask

   task automatic test_reset_mid();
      clear_mon();
      send_bit(1'b1);
      send_bit(1'b0);
      level(1'b0, 3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (intf.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_busy got %b want 0", intf.busy);
      end
      level(1'b1, 20);
      send_byte(8'hFF);
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 1 || (got_bytes.size() == 1 && got_bytes[0] !== 8'hFF)) begin
         failures++;
         $display("FAIL reset_mid_byte got %0d bytes want 1 byte ff", got_bytes.size());
      end
      checks++;
      if (n_done !== 1 || last_cnt !== 1 || n_err !== 0) begin
         failures++;
         $display("FAIL reset_mid_done got done=%0d cnt=%0d err=%0d want 1,1,0", n_done, last_cnt, n_err);
      end
   endtask

   task automatic test_saturate();
      clear_mon();
      for (int i = 0; i < 65; i++) send_byte(8'(i * 3));
      send_stop_idle(24);
      checks++;
      if (got_bytes.size() !== 65) begin
         failures++;
         $display("FAIL sat_count got %0d want 65", got_bytes.size());
      end else begin
         checks++;
         if (got_bytes[0] !== 8'h00 || got_bytes[64] !== 8'hC0) begin
            failures++;
            $display("FAIL sat_bytes got first=%h last=%h want 00,c0", got_bytes[0], got_bytes[64]);
         end
      end
      checks++;
      if (n_done !== 1 || last_cnt !== 63 || n_err !== 0) begin
         failures++;
         $display("FAIL sat_done got done=%0d cnt=%0d err=%0d want 1,63,0", n_done, last_cnt, n_err);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      frame_active = 1'b0;
      clear_mon();
      rst_n = 1'b0;
      intf.data_rx = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_01();
      test_zero_busy();
      test_multi();
      test_long_low();
      test_partial();
      test_stop_only();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
